// File: rtl/fmap_arbiter.sv
// Two-client arbiter in front of a single read-first BRAM holding a feature map.
// Read and write ports are arbitrated independently (round-robin), a client may
// lock both ports, and a granted read that hits a same-cycle write is forwarded.
module fmap_arbiter #(
   parameter int COORD_BITS = 8,
   parameter int IMG_WIDTH  = 32,
   parameter int IMG_HEIGHT = 32,
   parameter int WORD_BITS  = 64,
   localparam int ADDR_BITS = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    c0_rd_req,
   input  logic [2*COORD_BITS-1:0] c0_rd_coord,
   output logic                    c0_rd_gnt,
   output logic                    c0_rd_valid,
   output logic [WORD_BITS-1:0]    c0_rd_data,
   input  logic                    c0_wr_req,
   input  logic [2*COORD_BITS-1:0] c0_wr_coord,
   input  logic [WORD_BITS-1:0]    c0_wr_data,
   output logic                    c0_wr_gnt,
   input  logic                    c0_lock,
   input  logic                    c1_rd_req,
   input  logic [2*COORD_BITS-1:0] c1_rd_coord,
   output logic                    c1_rd_gnt,
   output logic                    c1_rd_valid,
   output logic [WORD_BITS-1:0]    c1_rd_data,
   input  logic                    c1_wr_req,
   input  logic [2*COORD_BITS-1:0] c1_wr_coord,
   input  logic [WORD_BITS-1:0]    c1_wr_data,
   output logic                    c1_wr_gnt,
   input  logic                    c1_lock,
   output logic                    bram_rd_en,
   output logic [ADDR_BITS-1:0]    bram_rd_addr,
   input  logic [WORD_BITS-1:0]    bram_rd_data,
   output logic                    bram_wr_en,
   output logic [ADDR_BITS-1:0]    bram_wr_addr,
   output logic [WORD_BITS-1:0]    bram_wr_data,
   output logic                    range_err
);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   state_t state, state_next;

   // Last-winner pointers: 1 means client 1 won the port most recently,
   // so the reset value of 1 makes client 0 the favoured one.
   logic rd_last, wr_last;
   logic rd_g0, rd_g1, wr_g0, wr_g1;

   logic                    rd_any, wr_any, rd_ok, wr_ok, fwd_hit;
   logic [2*COORD_BITS-1:0] rd_coord, wr_coord;
   logic [ADDR_BITS-1:0]    rd_addr, wr_addr;
   logic [WORD_BITS-1:0]    wr_word, rd_word;

   logic                    rd_valid_q, rd_client_q, rd_zero_q, fwd_hit_q, range_err_q;
   logic [WORD_BITS-1:0]    fwd_data_q;

   function automatic logic coord_ok(input logic [2*COORD_BITS-1:0] c);
      logic [31:0] x, y;
      x = 32'(c[2*COORD_BITS-1:COORD_BITS]);
      y = 32'(c[COORD_BITS-1:0]);
      return (x < 32'(IMG_WIDTH)) && (y < 32'(IMG_HEIGHT));
   endfunction

   function automatic logic [ADDR_BITS-1:0] coord_addr(input logic [2*COORD_BITS-1:0] c);
      logic [31:0] x, y;
      x = 32'(c[2*COORD_BITS-1:COORD_BITS]);
      y = 32'(c[COORD_BITS-1:0]);
      return ADDR_BITS'(y * 32'(IMG_WIDTH) + x);
   endfunction

   // Ownership state register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Grants and ownership transitions; nothing is granted while reset is held.
   always_comb begin
      rd_g0      = 1'b0;
      rd_g1      = 1'b0;
      wr_g0      = 1'b0;
      wr_g1      = 1'b0;
      state_next = state;
      if (rst_n) begin
         case (state)
            IDLE: begin
               if (c0_rd_req && c1_rd_req) begin
                  rd_g0 = rd_last;
                  rd_g1 = !rd_last;
               end else begin
                  rd_g0 = c0_rd_req;
                  rd_g1 = c1_rd_req;
               end
               if (c0_wr_req && c1_wr_req) begin
                  wr_g0 = wr_last;
                  wr_g1 = !wr_last;
               end else begin
                  wr_g0 = c0_wr_req;
                  wr_g1 = c1_wr_req;
               end
               if (c0_lock && (rd_g0 || wr_g0) && c1_lock && (rd_g1 || wr_g1))
                  state_next = rd_last ? OWN0 : OWN1;
               else if (c0_lock && (rd_g0 || wr_g0))
                  state_next = OWN0;
               else if (c1_lock && (rd_g1 || wr_g1))
                  state_next = OWN1;
            end
            OWN0: begin
               rd_g0 = c0_rd_req;
               wr_g0 = c0_wr_req;
               if (!c0_lock) state_next = IDLE;
            end
            OWN1: begin
               rd_g1 = c1_rd_req;
               wr_g1 = c1_wr_req;
               if (!c1_lock) state_next = IDLE;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // BRAM port drive from the granted request; out-of-range coordinates never enable the BRAM.
   always_comb begin
      rd_any       = rd_g0 || rd_g1;
      wr_any       = wr_g0 || wr_g1;
      rd_coord     = rd_g1 ? c1_rd_coord : c0_rd_coord;
      wr_coord     = wr_g1 ? c1_wr_coord : c0_wr_coord;
      wr_word      = wr_g1 ? c1_wr_data  : c0_wr_data;
      rd_ok        = coord_ok(rd_coord);
      wr_ok        = coord_ok(wr_coord);
      rd_addr      = coord_addr(rd_coord);
      wr_addr      = coord_addr(wr_coord);
      bram_rd_en   = rd_any && rd_ok;
      bram_wr_en   = wr_any && wr_ok;
      bram_rd_addr = bram_rd_en ? rd_addr : '0;
      bram_wr_addr = bram_wr_en ? wr_addr : '0;
      bram_wr_data = bram_wr_en ? wr_word : '0;
      fwd_hit      = bram_rd_en && bram_wr_en && (rd_addr == wr_addr);
   end

   // Round-robin pointers, read-return bookkeeping, write forwarding and the sticky range flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_last     <= 1'b1;
         wr_last     <= 1'b1;
         rd_valid_q  <= 1'b0;
         rd_client_q <= 1'b0;
         rd_zero_q   <= 1'b0;
         fwd_hit_q   <= 1'b0;
         fwd_data_q  <= '0;
         range_err_q <= 1'b0;
      end else begin
         if (rd_any) rd_last <= rd_g1;
         if (wr_any) wr_last <= wr_g1;
         rd_valid_q  <= rd_any;
         rd_client_q <= rd_g1;
         rd_zero_q   <= rd_any && !rd_ok;
         fwd_hit_q   <= fwd_hit;
         if (fwd_hit) fwd_data_q <= wr_word;
         if ((rd_any && !rd_ok) || (wr_any && !wr_ok)) range_err_q <= 1'b1;
      end
   end

   // Returned data selection; outputs are forced quiet while reset is held.
   always_comb begin
      rd_word     = rd_zero_q ? '0 : (fwd_hit_q ? fwd_data_q : bram_rd_data);
      c0_rd_gnt   = rd_g0;
      c1_rd_gnt   = rd_g1;
      c0_wr_gnt   = wr_g0;
      c1_wr_gnt   = wr_g1;
      c0_rd_valid = rst_n && rd_valid_q && !rd_client_q;
      c1_rd_valid = rst_n && rd_valid_q && rd_client_q;
      c0_rd_data  = c0_rd_valid ? rd_word : '0;
      c1_rd_data  = c1_rd_valid ? rd_word : '0;
      range_err   = rst_n && range_err_q;
   end

endmodule

// File: tb/tb_fmap_arbiter.sv
// Bench for fmap_arbiter: a read-first BRAM model behind the DUT, a reference
// memory, and a queue of expected read returns checked when rd_valid appears.
module tb_fmap_arbiter;

   logic        clk;
   logic        rst_n;
   logic        c0_rd_req, c1_rd_req, c0_wr_req, c1_wr_req, c0_lock, c1_lock;
   logic [15:0] c0_rd_coord, c1_rd_coord, c0_wr_coord, c1_wr_coord;
   logic [63:0] c0_wr_data, c1_wr_data;
   logic        c0_rd_gnt, c1_rd_gnt, c0_wr_gnt, c1_wr_gnt, c0_rd_valid, c1_rd_valid;
   logic [63:0] c0_rd_data, c1_rd_data;
   logic        bram_rd_en, bram_wr_en, range_err;
   logic [9:0]  bram_rd_addr, bram_wr_addr;
   logic [63:0] bram_rd_data, bram_wr_data;

   typedef struct {
      logic        client;
      logic [63:0] data;
   } rd_exp_t;

   rd_exp_t     sbQ[$];
   logic [63:0] bramMem[1024];
   logic [63:0] refMem[1024];
   int          checks = 0;
   int          errors = 0;

   fmap_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .c0_rd_req(c0_rd_req), .c0_rd_coord(c0_rd_coord), .c0_rd_gnt(c0_rd_gnt),
      .c0_rd_valid(c0_rd_valid), .c0_rd_data(c0_rd_data),
      .c0_wr_req(c0_wr_req), .c0_wr_coord(c0_wr_coord), .c0_wr_data(c0_wr_data),
      .c0_wr_gnt(c0_wr_gnt), .c0_lock(c0_lock),
      .c1_rd_req(c1_rd_req), .c1_rd_coord(c1_rd_coord), .c1_rd_gnt(c1_rd_gnt),
      .c1_rd_valid(c1_rd_valid), .c1_rd_data(c1_rd_data),
      .c1_wr_req(c1_wr_req), .c1_wr_coord(c1_wr_coord), .c1_wr_data(c1_wr_data),
      .c1_wr_gnt(c1_wr_gnt), .c1_lock(c1_lock),
      .bram_rd_en(bram_rd_en), .bram_rd_addr(bram_rd_addr), .bram_rd_data(bram_rd_data),
      .bram_wr_en(bram_wr_en), .bram_wr_addr(bram_wr_addr), .bram_wr_data(bram_wr_data),
      .range_err(range_err)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Read-first BRAM with one cycle of read latency.
   always @(posedge clk) begin
      if (bram_rd_en) bram_rd_data <= bramMem[bram_rd_addr];
      if (bram_wr_en) bramMem[bram_wr_addr] <= bram_wr_data;
   end

   function automatic logic [15:0] xy(input int x, input int y);
      return {8'(x), 8'(y)};
   endfunction

   function automatic bit inRange(input logic [15:0] c);
      return (c[15:8] < 8'd32) && (c[7:0] < 8'd32);
   endfunction

   function automatic int refAddr(input logic [15:0] c);
      return int'(c[7:0]) * 32 + int'(c[15:8]);
   endfunction

   task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input int client, input logic rd, input logic [15:0] rc,
                                input logic wr, input logic [15:0] wc, input logic [63:0] wd,
                                input logic lock);
      if (client == 0) begin
         c0_rd_req = rd; c0_rd_coord = rc; c0_wr_req = wr; c0_wr_coord = wc;
         c0_wr_data = wd; c0_lock = lock;
      end else begin
         c1_rd_req = rd; c1_rd_coord = rc; c1_wr_req = wr; c1_wr_coord = wc;
         c1_wr_data = wd; c1_lock = lock;
      end
   endtask

   task automatic clearAll();
      applyStimulus(0, 1'b0, 16'h0, 1'b0, 16'h0, 64'h0, 1'b0);
      applyStimulus(1, 1'b0, 16'h0, 1'b0, 16'h0, 64'h0, 1'b0);
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Compares any read return due this cycle against the oldest expectation.
   task automatic scoreboardCheck(input string tag);
      rd_exp_t e;
      if (sbQ.size() != 0) begin
         e = sbQ.pop_front();
         checkOutput({tag, " rd_valid"}, {c0_rd_valid, c1_rd_valid}, e.client ? 2'b01 : 2'b10);
         checkOutput({tag, " rd_data"}, e.client ? c1_rd_data : c0_rd_data, e.data);
      end else begin
         checkOutput({tag, " no_valid"}, {c0_rd_valid, c1_rd_valid}, 2'b00);
      end
   endtask

   // Samples on the falling edge: checks returns and grants, then records expectations.
   task automatic sampleCheck(input string tag, input logic er0, input logic er1,
                              input logic ew0, input logic ew1);
      @(negedge clk);
      scoreboardCheck(tag);
      checkOutput({tag, " gnt"}, {c0_rd_gnt, c1_rd_gnt, c0_wr_gnt, c1_wr_gnt}, {er0, er1, ew0, ew1});
      if (ew0 && inRange(c0_wr_coord)) refMem[refAddr(c0_wr_coord)] = c0_wr_data;
      if (ew1 && inRange(c1_wr_coord)) refMem[refAddr(c1_wr_coord)] = c1_wr_data;
      if (er0) sbQ.push_back('{1'b0, inRange(c0_rd_coord) ? refMem[refAddr(c0_rd_coord)] : 64'h0});
      if (er1) sbQ.push_back('{1'b1, inRange(c1_rd_coord) ? refMem[refAddr(c1_rd_coord)] : 64'h0});
   endtask

   task automatic checkResetOutputs(input string tag);
      @(negedge clk);
      checkOutput({tag, " ctl"}, {c0_rd_gnt, c1_rd_gnt, c0_wr_gnt, c1_wr_gnt, c0_rd_valid,
                                  c1_rd_valid, bram_rd_en, bram_wr_en, range_err}, 9'h0);
      checkOutput({tag, " rd_data"}, {c0_rd_data, c1_rd_data}, 128'h0);
      checkOutput({tag, " bram"}, {bram_rd_addr, bram_wr_addr, bram_wr_data}, 84'h0);
   endtask

   // Directed sequence; read data is predicted from the reference memory.
   initial begin
      for (int i = 0; i < 1024; i++) begin
         bramMem[i] = 64'h0;
         refMem[i]  = 64'h0;
      end
      bram_rd_data = 64'h0;
      clearAll();
      rst_n = 1'b0;
      applyStimulus(0, 1'b1, xy(1, 1), 1'b0, 16'h0, 64'h0, 1'b1);
      applyStimulus(1, 1'b0, 16'h0, 1'b1, xy(40, 0), 64'h55, 1'b0);
      nextCycle();
      checkResetOutputs("reset");
      nextCycle();
      rst_n = 1'b1;
      clearAll();
      sampleCheck("idle", 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("idle range_err", range_err, 1'b0);
      nextCycle();

      // Preload through client 0 writes.
      for (int i = 0; i < 6; i++) begin
         applyStimulus(0, 1'b0, 16'h0, 1'b1, xy(i + 1, i + 2), 64'hC0DE_0000_0000_0000 | 64'(i), 1'b0);
         sampleCheck("preload", 1'b0, 1'b0, 1'b1, 1'b0);
         nextCycle();
      end

      // Both clients read every cycle: grants alternate starting with client 0.
      for (int i = 0; i < 6; i++) begin
         applyStimulus(0, 1'b1, xy(i + 1, i + 2), 1'b0, 16'h0, 64'h0, 1'b0);
         applyStimulus(1, 1'b1, xy(i + 2, i + 3), 1'b0, 16'h0, 64'h0, 1'b0);
         sampleCheck("rr", (i % 2) == 0, (i % 2) == 1, 1'b0, 1'b0);
         nextCycle();
      end
      clearAll();
      sampleCheck("rr drain", 1'b0, 1'b0, 1'b0, 1'b0);
      nextCycle();

      // Same-cycle write and read of (3,4) must forward the new word.
      applyStimulus(0, 1'b0, 16'h0, 1'b1, xy(3, 4), 64'hA5A5_A5A5_A5A5_A5A5, 1'b0);
      applyStimulus(1, 1'b1, xy(3, 4), 1'b0, 16'h0, 64'h0, 1'b0);
      sampleCheck("fwd", 1'b0, 1'b1, 1'b1, 1'b0);
      checkOutput("fwd wr_addr", bram_wr_addr, 10'd131);
      nextCycle();
      clearAll();
      sampleCheck("fwd drain", 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("pre-oor range_err", range_err, 1'b0);
      nextCycle();

      // Out-of-range read: granted, BRAM untouched, zero data, sticky error.
      applyStimulus(1, 1'b1, xy(32, 0), 1'b0, 16'h0, 64'h0, 1'b0);
      sampleCheck("oor", 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("oor rd_en", bram_rd_en, 1'b0);
      nextCycle();
      clearAll();
      sampleCheck("oor drain", 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("oor range_err", range_err, 1'b1);
      nextCycle();
      sampleCheck("oor hold", 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("oor range_err hold", range_err, 1'b1);
      nextCycle();

      // Client 0 locks for nine cycles while client 1 keeps requesting.
      for (int i = 0; i < 9; i++) begin
         applyStimulus(0, 1'b1, xy(i, 1), 1'b1, xy(i, 2), 64'h100 + 64'(i), 1'b1);
         if (i > 0) applyStimulus(1, 1'b1, xy(5, 5), 1'b1, xy(6, 6), 64'hBEEF, 1'b0);
         sampleCheck("lock", 1'b1, 1'b0, 1'b1, 1'b0);
         nextCycle();
      end
      applyStimulus(0, 1'b0, 16'h0, 1'b0, 16'h0, 64'h0, 1'b0);
      sampleCheck("lock drop", 1'b0, 1'b0, 1'b0, 1'b0);
      nextCycle();
      sampleCheck("unlocked", 1'b0, 1'b1, 1'b0, 1'b1);
      nextCycle();
      clearAll();

      // Write-port contention after client 1 won last: client 0 first, then client 1.
      applyStimulus(0, 1'b0, 16'h0, 1'b1, xy(10, 10), 64'h1010, 1'b0);
      applyStimulus(1, 1'b0, 16'h0, 1'b1, xy(11, 11), 64'h1111, 1'b0);
      sampleCheck("wr rr0", 1'b0, 1'b0, 1'b1, 1'b0);
      nextCycle();
      applyStimulus(0, 1'b0, 16'h0, 1'b1, xy(12, 12), 64'h1212, 1'b0);
      sampleCheck("wr rr1", 1'b0, 1'b0, 1'b0, 1'b1);
      nextCycle();
      clearAll();
      applyStimulus(0, 1'b1, xy(10, 10), 1'b0, 16'h0, 64'h0, 1'b0);
      applyStimulus(1, 1'b1, xy(11, 11), 1'b0, 16'h0, 64'h0, 1'b0);
      sampleCheck("rd back0", 1'b1, 1'b0, 1'b0, 1'b0);
      nextCycle();
      applyStimulus(0, 1'b0, 16'h0, 1'b0, 16'h0, 64'h0, 1'b0);
      sampleCheck("rd back1", 1'b0, 1'b1, 1'b0, 1'b0);
      nextCycle();
      clearAll();
      sampleCheck("rd back drain", 1'b0, 1'b0, 1'b0, 1'b0);
      nextCycle();

      // Reset one cycle after a grant: no return, pointer back to client 0.
      applyStimulus(0, 1'b1, xy(1, 2), 1'b0, 16'h0, 64'h0, 1'b0);
      sampleCheck("pre-rst", 1'b1, 1'b0, 1'b0, 1'b0);
      nextCycle();
      rst_n = 1'b0;
      applyStimulus(1, 1'b1, xy(2, 3), 1'b0, 16'h0, 64'h0, 1'b0);
      checkResetOutputs("mid-rst");
      sbQ.delete();
      nextCycle();
      rst_n = 1'b1;
      sampleCheck("post-rst0", 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("post-rst range_err", range_err, 1'b0);
      nextCycle();
      sampleCheck("post-rst1", 1'b0, 1'b1, 1'b0, 1'b0);
      nextCycle();
      clearAll();
      sampleCheck("post-rst drain", 1'b0, 1'b0, 1'b0, 1'b0);
      nextCycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
